// File: rtl/pos2num_pkg.sv
// Grid geometry and scan FSM states shared by the grid-to-index scanner and the index decoder.
package pos2num_pkg;
  localparam int GRID_ROWS = 23;
  localparam int GRID_COLS = 31;
  localparam int GRID_N    = GRID_ROWS * GRID_COLS;
  localparam int NUM_W     = 14;
  localparam int ROW_W     = $clog2(GRID_ROWS);
  localparam int COL_W     = $clog2(GRID_COLS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;
endpackage

// File: rtl/pos2num_row_enc.sv
// Combinational lowest-set-bit encoder for one grid row: hit, column of the lowest set bit,
// and whether two or more bits are set.
module pos2num_row_enc
  import pos2num_pkg::*;
#(
  parameter int COLS = GRID_COLS,
  parameter int CW   = COL_W
) (
  input  logic [COLS-1:0] i_bits,
  output logic            o_hit,
  output logic            o_two,
  output logic [CW-1:0]   o_hcol
);

  logic [COLS-1:0] w_low_clr;

  // Clearing the lowest set bit leaves something behind only if two or more were set.
  assign w_low_clr = i_bits & (i_bits - COLS'(1));
  assign o_hit     = |i_bits;
  assign o_two     = |w_low_clr;

  always_comb begin
    o_hcol = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (i_bits[i]) o_hcol = CW'(i);
    end
  end

endmodule

// File: rtl/pos2num_scan.sv
// One-hot ROWS x COLS grid to linear index (row*COLS+col), one row per clock via start/done.
// done pulses one cycle, ROWS edges after the start edge; start is ignored unless IDLE.
module pos2num_scan
  import pos2num_pkg::*;
#(
  parameter int ROWS   = GRID_ROWS,
  parameter int COLS   = GRID_COLS,
  parameter int NUM_WD = NUM_W,
  parameter int ROW_WD = ROW_W,
  parameter int COL_WD = COL_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ROWS*COLS-1:0] grid,
  output logic                 busy,
  output logic                 done,
  output logic                 found,
  output logic                 multi,
  output logic [ROW_WD-1:0]    row,
  output logic [COL_WD-1:0]    col,
  output logic [NUM_WD-1:0]    num
);

  scan_state_t           r_state;
  scan_state_t           w_state_nxt;
  logic [ROWS*COLS-1:0]  r_snap;
  logic [ROW_WD-1:0]     r_rc;
  logic [NUM_WD-1:0]     r_base;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_found;
  logic                  r_multi;
  logic [ROW_WD-1:0]     r_row;
  logic [COL_WD-1:0]     r_col;
  logic [NUM_WD-1:0]     r_num;

  logic                  w_hit;
  logic                  w_two;
  logic [COL_WD-1:0]     w_hcol;
  logic                  w_last_row;

  // The snapshot shifts down one row per scan step, so the current row is always the low slice.
  pos2num_row_enc #(
    .COLS (COLS),
    .CW   (COL_WD)
  ) u_row_enc (
    .i_bits (r_snap[COLS-1:0]),
    .o_hit  (w_hit),
    .o_two  (w_two),
    .o_hcol (w_hcol)
  );

  assign w_last_row = (r_rc == ROW_WD'(ROWS - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = SCAN;
      SCAN:    if (w_last_row) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_snap  <= '0;
      r_rc    <= '0;
      r_base  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_found <= 1'b0;
      r_multi <= 1'b0;
      r_row   <= '0;
      r_col   <= '0;
      r_num   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == SCAN);
      r_done  <= (w_state_nxt == DONE);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_snap  <= grid;
            r_rc    <= '0;
            r_base  <= '0;
            r_found <= 1'b0;
            r_multi <= 1'b0;
            r_row   <= '0;
            r_col   <= '0;
            r_num   <= '0;
          end
        end
        SCAN: begin
          if (w_hit && !r_found) begin
            r_row   <= r_rc;
            r_col   <= w_hcol;
            r_num   <= r_base + NUM_WD'(w_hcol);
            r_found <= 1'b1;
          end
          if ((w_hit && r_found) || w_two) r_multi <= 1'b1;
          r_snap <= r_snap >> COLS;
          r_rc   <= r_rc + ROW_WD'(1);
          r_base <= r_base + NUM_WD'(COLS);
        end
        default: ;
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign found = r_found;
  assign multi = r_multi;
  assign row   = r_row;
  assign col   = r_col;
  assign num   = r_num;

endmodule

// File: tb/tb_pos2num_scan.sv
// Directed bench for pos2num_scan: fixed latency, single/multi/empty grids, ignored starts,
// snapshot isolation, async reset abort and a full index round trip.
module tb_pos2num_scan;
  import pos2num_pkg::*;

  localparam int N   = GRID_N;
  localparam int LAT = GRID_ROWS;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [N-1:0]     grid;
  logic             busy;
  logic             done;
  logic             found;
  logic             multi;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic [NUM_W-1:0] num;

  int n_vec;
  int n_err;

  pos2num_scan dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .grid  (grid),
    .busy  (busy),
    .done  (done),
    .found (found),
    .multi (multi),
    .row   (row),
    .col   (col),
    .num   (num)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Returns the number of negedges after the start edge at which done was first seen (40 = timeout).
  task automatic do_scan(input logic [N-1:0] g, output int cyc);
    @(negedge clk);
    grid  = g;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    logic [N-1:0] g;
    logic [N-1:0] g2;
    int cyc;
    int n_done;
    int first_done;

    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    grid  = '0;

    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_found", 32'(found), 0);
    chk("rst_multi", 32'(multi), 0);
    chk("rst_num", 32'(num), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1: bit 0 only
    g = '0; g[0] = 1'b1;
    do_scan(g, cyc);
    chk("t1_latency", 32'(cyc), 32'(LAT));
    chk("t1_found", 32'(found), 1);
    chk("t1_multi", 32'(multi), 0);
    chk("t1_row", 32'(row), 0);
    chk("t1_col", 32'(col), 0);
    chk("t1_num", 32'(num), 0);

    // start during the DONE cycle must be ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("donecyc_start_busy", 32'(busy), 0);
    chk("done_single_pulse", 32'(done), 0);
    @(negedge clk);
    chk("donecyc_start_busy2", 32'(busy), 0);
    chk("hold_found", 32'(found), 1);

    // 2: last cell (22,30)
    g = '0; g[712] = 1'b1;
    do_scan(g, cyc);
    chk("t2_latency", 32'(cyc), 32'(LAT));
    chk("t2_row", 32'(row), 22);
    chk("t2_col", 32'(col), 30);
    chk("t2_num", 32'(num), 712);
    chk("t2_multi", 32'(multi), 0);

    // 3: empty grid, one done pulse only
    do_scan('0, cyc);
    chk("t3_latency", 32'(cyc), 32'(LAT));
    chk("t3_found", 32'(found), 0);
    chk("t3_multi", 32'(multi), 0);
    chk("t3_num", 32'(num), 0);
    n_done = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("t3_extra_done", 32'(n_done), 0);

    // 4a: (3,5) and (10,2)
    g = '0; g[98] = 1'b1; g[312] = 1'b1;
    do_scan(g, cyc);
    chk("t4a_num", 32'(num), 98);
    chk("t4a_row", 32'(row), 3);
    chk("t4a_col", 32'(col), 5);
    chk("t4a_multi", 32'(multi), 1);

    // 4b: row 0, cols 4 and 7
    g = '0; g[4] = 1'b1; g[7] = 1'b1;
    do_scan(g, cyc);
    chk("t4b_num", 32'(num), 4);
    chk("t4b_multi", 32'(multi), 1);

    // 5a: restart attempt at edge 5 plus grid change mid-scan
    g  = '0; g[98] = 1'b1;
    g2 = '0; g2[0] = 1'b1; g2[700] = 1'b1;
    @(negedge clk);
    grid  = g;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    grid  = g2;
    @(negedge clk);
    start = 1'b0;
    cyc = 5;
    n_done = 0;
    first_done = -1;
    repeat (60) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        n_done++;
        if (first_done < 0) first_done = cyc;
      end
    end
    chk("t5_done_count", 32'(n_done), 1);
    chk("t5_done_cycle", 32'(first_done), 32'(LAT));
    chk("t5_num", 32'(num), 98);
    chk("t5_multi", 32'(multi), 0);

    // 5b: asynchronous reset at edge 10 aborts the scan
    g = '0; g[0] = 1'b1; g[5] = 1'b1;
    @(negedge clk);
    grid  = g;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("t5b_pre_found", 32'(found), 1);
    chk("t5b_pre_busy", 32'(busy), 1);
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5b_busy", 32'(busy), 0);
    chk("t5b_done", 32'(done), 0);
    chk("t5b_found", 32'(found), 0);
    chk("t5b_multi", 32'(multi), 0);
    chk("t5b_num", 32'(num), 0);
    chk("t5b_row", 32'(row), 0);
    chk("t5b_col", 32'(col), 0);
    n_done = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) n_done++;
    end
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    chk("t5b_no_done", 32'(n_done), 0);

    // 6: round trip over every cell index
    for (int n = 0; n < N; n++) begin
      g = '0;
      g[n] = 1'b1;
      do_scan(g, cyc);
      chk($sformatf("rt_num_%0d", n), 32'(num), 32'(n));
      chk($sformatf("rt_found_%0d", n), 32'(found), 1);
      chk($sformatf("rt_multi_%0d", n), 32'(multi), 0);
      if (n % 97 == 0) chk($sformatf("rt_lat_%0d", n), 32'(cyc), 32'(LAT));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
